// File: rtl/ro_scan_sequencer.sv
// ro_scan_sequencer
//   Time-multiplexes N_OSC ring oscillators onto one shared gate counter. For
//   each oscillator the block enables it, lets it settle with the counter held
//   clear, gates the counter for WIN_CYC cycles, latches the count, and sends
//   a frame to the UART TX side: {4'hA, idx}, res[7:0], res[15:8].
//
//   Optional feature macro: SEQ_CHECKSUM_EN. When it is defined, a fourth byte
//   (id ^ lo ^ hi) follows each frame using the same handshake.
//
// Ports
//   clk, reset   rising-edge clock, synchronous active-high reset
//   start        one-cycle pulse that begins a scan pass (ignored while busy)
//   continuous   restart the pass automatically after the last oscillator
//   osc_mask     oscillators to include; sampled at the start of each pass
//   osc_en       one-hot (or zero) enable to the oscillator bank
//   cnt_clr      clear to the shared counter
//   cnt_en       counter gate
//   count        counter value, valid 2 cycles after cnt_en falls
//   tx_data      byte to the UART, valid while tx_start is high
//   tx_start     one-cycle transmit pulse
//   tx_busy      UART transmitting
//   busy         pass in progress
//   done         one-cycle pulse at the end of each pass
module ro_scan_sequencer #(
  parameter int N_OSC      = 4,
  parameter int CNT_W      = 16,
  parameter int SETTLE_CYC = 32,
  parameter int WIN_CYC    = 1000
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             continuous,
  input  logic [N_OSC-1:0] osc_mask,
  output logic [N_OSC-1:0] osc_en,
  output logic             cnt_clr,
  output logic             cnt_en,
  input  logic [CNT_W-1:0] count,
  output logic [7:0]       tx_data,
  output logic             tx_start,
  input  logic             tx_busy,
  output logic             busy,
  output logic             done
);

  localparam int CYC_MAX = (WIN_CYC > SETTLE_CYC) ? WIN_CYC : SETTLE_CYC;
  localparam int CYC_W   = $clog2(CYC_MAX + 1);

  typedef enum logic [3:0] {
    IDLE,
    SELECT,
    SETTLE,
    GATE,
    HOLD,
    TX_ID,
    TX_LO,
    TX_HI,
`ifdef SEQ_CHECKSUM_EN
    TX_CK,
`endif
    NEXT
  } state_t;

  state_t             state_q, state_d;
  logic [3:0]         idx_q, idx_d;
  logic [N_OSC-1:0]   mask_q, mask_d;
  logic [CYC_W-1:0]   cyc_q, cyc_d;
  logic [15:0]        res_q, res_d;
  // 0: waiting for tx_busy low, 1: the cycle after tx_start, where tx_busy
  // may not yet reflect the new byte and is ignored.
  logic               tx_ph_q, tx_ph_d;

  // Counter result normalised to 16 bits (truncate or zero-extend).
  logic [15:0] cnt16;
  generate
    if (CNT_W >= 16) begin : g_trunc
      assign cnt16 = count[15:0];
    end else begin : g_zext
      assign cnt16 = {{(16 - CNT_W){1'b0}}, count};
    end
  endgenerate

  // Lowest set mask bit at/above idx_q, and whether any set bit lies above it.
  logic [3:0] sel_idx;
  logic       has_next;
  always_comb begin
    sel_idx  = idx_q;
    has_next = 1'b0;
    for (int i = N_OSC - 1; i >= 0; i--) begin
      if (mask_q[i] && (i >= int'(idx_q))) sel_idx = 4'(i);
    end
    for (int i = 0; i < N_OSC; i++) begin
      if (mask_q[i] && (i > int'(idx_q))) has_next = 1'b1;
    end
  end

  logic [7:0] id_byte, tx_byte;
  assign id_byte = {4'hA, idx_q};

  always_comb begin
    case (state_q)
      TX_ID:   tx_byte = id_byte;
      TX_LO:   tx_byte = res_q[7:0];
      TX_HI:   tx_byte = res_q[15:8];
`ifdef SEQ_CHECKSUM_EN
      TX_CK:   tx_byte = id_byte ^ res_q[7:0] ^ res_q[15:8];
`endif
      default: tx_byte = 8'h00;
    endcase
  end

  logic osc_on, tx_go, done_raw;

  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    mask_d   = mask_q;
    cyc_d    = cyc_q;
    res_d    = res_q;
    tx_ph_d  = tx_ph_q;
    osc_on   = 1'b0;
    cnt_clr  = 1'b1;
    cnt_en   = 1'b0;
    tx_go    = 1'b0;
    done_raw = 1'b0;

    case (state_q)
      IDLE: begin
        if (start) begin
          mask_d = osc_mask;
          idx_d  = 4'd0;
          if (osc_mask == '0) done_raw = 1'b1;
          else                state_d  = SELECT;
        end
      end
      SELECT: begin
        idx_d   = sel_idx;
        cyc_d   = '0;
        state_d = SETTLE;
      end
      SETTLE: begin
        osc_on = 1'b1;
        if (cyc_q == CYC_W'(SETTLE_CYC - 1)) begin
          cyc_d   = '0;
          state_d = GATE;
        end else begin
          cyc_d = cyc_q + 1'b1;
        end
      end
      GATE: begin
        osc_on  = 1'b1;
        cnt_clr = 1'b0;
        cnt_en  = 1'b1;
        if (cyc_q == CYC_W'(WIN_CYC - 1)) begin
          cyc_d   = '0;
          state_d = HOLD;
        end else begin
          cyc_d = cyc_q + 1'b1;
        end
      end
      HOLD: begin
        // Counter output lags the gate by two cycles; keep it uncleared.
        osc_on  = 1'b1;
        cnt_clr = 1'b0;
        if (cyc_q == CYC_W'(1)) begin
          res_d   = cnt16;
          tx_ph_d = 1'b0;
          state_d = TX_ID;
        end else begin
          cyc_d = cyc_q + 1'b1;
        end
      end
      TX_ID, TX_LO, TX_HI
`ifdef SEQ_CHECKSUM_EN
      , TX_CK
`endif
      : begin
        if (!tx_ph_q) begin
          if (!tx_busy) begin
            tx_go   = 1'b1;
            tx_ph_d = 1'b1;
          end
        end else begin
          tx_ph_d = 1'b0;
          case (state_q)
            TX_ID:   state_d = TX_LO;
            TX_LO:   state_d = TX_HI;
`ifdef SEQ_CHECKSUM_EN
            TX_HI:   state_d = TX_CK;
`endif
            default: state_d = NEXT;
          endcase
        end
      end
      NEXT: begin
        if (has_next) begin
          idx_d   = idx_q + 4'd1;
          state_d = SELECT;
        end else begin
          done_raw = 1'b1;
          if (continuous) begin
            mask_d  = osc_mask;
            idx_d   = 4'd0;
            state_d = (osc_mask != '0) ? SELECT : IDLE;
          end else begin
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Pulses are suppressed in the reset cycle so reset beats a coincident start.
  always_comb begin
    for (int i = 0; i < N_OSC; i++) osc_en[i] = osc_on && (4'(i) == idx_q);
  end
  assign tx_start = tx_go & ~reset;
  assign tx_data  = tx_start ? tx_byte : 8'h00;
  assign done     = done_raw & ~reset;
  assign busy     = (state_q != IDLE);

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      idx_q   <= 4'd0;
      mask_q  <= '0;
      cyc_q   <= '0;
      res_q   <= 16'h0000;
      tx_ph_q <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      mask_q  <= mask_d;
      cyc_q   <= cyc_d;
      res_q   <= res_d;
      tx_ph_q <= tx_ph_d;
    end
  end

endmodule

// File: tb/tb_ro_scan_sequencer.sv
module tb_ro_scan_sequencer;
  localparam int N_OSC  = 4;
  localparam int CNT_W  = 16;
  localparam int SETTLE = 32;
  localparam int WIN    = 1000;

  logic             clk = 1'b0;
  logic             reset = 1'b1;
  logic             start = 1'b0;
  logic             continuous = 1'b0;
  logic [N_OSC-1:0] osc_mask = '0;
  logic [N_OSC-1:0] osc_en;
  logic             cnt_clr, cnt_en;
  logic [CNT_W-1:0] count = '0;
  logic [7:0]       tx_data;
  logic             tx_start;
  logic             tx_busy;
  logic             busy, done;

  ro_scan_sequencer #(.N_OSC(N_OSC), .CNT_W(CNT_W), .SETTLE_CYC(SETTLE), .WIN_CYC(WIN)) dut (
    .clk(clk), .reset(reset), .start(start), .continuous(continuous), .osc_mask(osc_mask),
    .osc_en(osc_en), .cnt_clr(cnt_clr), .cnt_en(cnt_en), .count(count), .tx_data(tx_data),
    .tx_start(tx_start), .tx_busy(tx_busy), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endfunction

  // Oscillator bank + counter model: each oscillator adds a fixed rate per
  // gated cycle; the counter output is one register behind the accumulator.
  logic [15:0] rate [N_OSC];
  logic [15:0] acc = '0;
  logic [15:0] cur_rate;
  always_comb begin
    cur_rate = '0;
    for (int i = 0; i < N_OSC; i++) if (osc_en[i]) cur_rate = rate[i];
  end
  always @(posedge clk) begin
    if (cnt_clr)     acc <= '0;
    else if (cnt_en) acc <= acc + cur_rate;
    count <= acc;
  end

  // UART model: busy for busy_len cycles after each accepted byte.
  int busy_len = 0;
  int busy_cnt = 0;
  logic start_seen = 1'b0;
  always @(posedge clk) begin
    if (start_seen)        busy_cnt <= busy_len;
    else if (busy_cnt > 0) busy_cnt <= busy_cnt - 1;
  end
  assign tx_busy = (busy_cnt != 0);

  // Reference model: a frame is the oscillator id, then the count the window
  // produces (rate * WIN, 16-bit wrap), low byte first.
  logic [7:0] exp_q[$];
  logic [N_OSC-1:0] allowed = '0;
  int done_cnt = 0;

  function automatic void push_frame(int i);
    logic [31:0] r;
    logic [7:0]  id, lo, hi;
    r  = rate[i] * WIN;
    id = 8'hA0 | 8'(i);
    lo = r[7:0];
    hi = r[15:8];
    exp_q.push_back(id);
    exp_q.push_back(lo);
    exp_q.push_back(hi);
`ifdef SEQ_CHECKSUM_EN
    exp_q.push_back(id ^ lo ^ hi);
`endif
  endfunction

  function automatic void push_pass(logic [N_OSC-1:0] m);
    for (int i = 0; i < N_OSC; i++) if (m[i]) push_frame(i);
  endfunction

  // Monitor / scoreboard
  logic cnt_en_prev = 1'b0;
  int   gate_len = 0;
  bit   gate_abort = 1'b0;
  bit   rise_pending = 1'b0;
  int   start_cyc = 0;
  always @(negedge clk) begin
    start_seen <= tx_start;
    if (!reset) begin
      chk("osc_en_onehot0", 32'($onehot0(osc_en)), 32'd1);
      chk("osc_en_allowed", 32'(osc_en & ~allowed), 32'd0);
    end
    if (tx_start) begin
      chk("tx_start_while_busy", 32'(tx_busy), 32'd0);
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_tx_start: got byte %h expected none (cycle %0d)", tx_data, cyc);
      end else begin
        logic [7:0] e;
        e = exp_q.pop_front();
        chk("tx_byte", 32'(tx_data), 32'(e));
      end
    end
    if (done) begin
      done_cnt++;
      // Continuous restart: a new pass begins with the freshly sampled mask.
      if (busy && continuous && osc_mask != '0) begin
        push_pass(osc_mask);
        allowed = osc_mask;
      end
    end
    if (reset) begin
      gate_abort   = 1'b1;
      rise_pending = 1'b0;
    end
    if (cnt_en && !cnt_en_prev) begin
      if (rise_pending) chk("gate_start_latency", 32'(cyc - start_cyc), 32'(SETTLE + 1));
      rise_pending = 1'b0;
      gate_abort   = reset;
      gate_len     = 1;
    end else if (cnt_en) begin
      gate_len++;
    end else if (cnt_en_prev) begin
      if (!gate_abort) chk("gate_len", 32'(gate_len), 32'(WIN));
      gate_abort = 1'b0;
    end
    cnt_en_prev = cnt_en;
  end

  task automatic do_start(input logic [N_OSC-1:0] m);
    @(negedge clk);
    osc_mask = m;
    allowed  = m;
    push_pass(m);
    start = 1'b1;
    @(negedge clk);
    start        = 1'b0;
    start_cyc    = cyc;
    rise_pending = (m != '0);
  endtask

  task automatic wait_done(input int target, input int budget, input string name);
    for (int k = 0; k < budget && done_cnt < target; k++) @(negedge clk);
    chk(name, 32'(done_cnt >= target), 32'd1);
  endtask

  task automatic idle_check(input string name);
    repeat (20) @(negedge clk);
    chk({name, "_busy"}, 32'(busy), 32'd0);
    chk({name, "_queue_empty"}, 32'(exp_q.size()), 32'd0);
  endtask

  task automatic new_rates();
    for (int i = 0; i < N_OSC; i++) rate[i] = 16'($urandom_range(1, 16'hFFFF));
  endtask

  initial begin
    int d0;
    logic [N_OSC-1:0] m;
    new_rates();

    // Reset state
    repeat (2) @(negedge clk);
    chk("rst_osc_en", 32'(osc_en), 32'd0);
    chk("rst_cnt_clr", 32'(cnt_clr), 32'd1);
    chk("rst_cnt_en", 32'(cnt_en), 32'd0);
    chk("rst_tx_start", 32'(tx_start), 32'd0);
    chk("rst_tx_data", 32'(tx_data), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    // start coincident with reset must be ignored
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("rst_start_ignored", 32'(busy), 32'd0);
    reset = 1'b0;

    // Sparse mask, with an ignored start pulse mid-pass
    busy_len = 3;
    d0 = done_cnt;
    do_start(4'b0101);
    repeat (100) @(negedge clk);
    osc_mask = 4'b1111;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_done(d0 + 1, 6000, "mask0101_done");
    idle_check("mask0101");
    chk("mask0101_done_once", 32'(done_cnt - d0), 32'd1);

    // Slow UART: 500 busy cycles per byte
    busy_len = 500;
    new_rates();
    d0 = done_cnt;
    do_start(4'b0110);
    wait_done(d0 + 1, 9000, "slow_uart_done");
    idle_check("slow_uart");

    // Random masks
    for (int t = 0; t < 3; t++) begin
      busy_len = $urandom_range(0, 20);
      new_rates();
      m = 4'($urandom_range(1, 15));
      d0 = done_cnt;
      do_start(m);
      wait_done(d0 + 1, 6000, "rand_done");
      idle_check("rand");
    end

    // Empty mask: immediate done, nothing sent
    d0 = done_cnt;
    do_start(4'b0000);
    repeat (5) @(negedge clk);
    chk("mask0_done", 32'(done_cnt - d0), 32'd1);
    idle_check("mask0");

    // Continuous on a single oscillator, then stop after the current frame
    busy_len = 2;
    new_rates();
    continuous = 1'b1;
    d0 = done_cnt;
    do_start(4'b1000);
    wait_done(d0 + 2, 4000, "cont_two_passes");
    @(negedge clk);
    continuous = 1'b0;
    wait_done(d0 + 3, 2000, "cont_stop_done");
    idle_check("cont_stop");
    chk("cont_pass_count", 32'(done_cnt - d0), 32'd3);

    // Reset in the middle of the gate window for oscillator 2
    do_start(4'b0100);
    for (int k = 0; k < 200 && !cnt_en; k++) @(negedge clk);
    repeat (50) @(negedge clk);
    chk("midgate_osc_en", 32'(osc_en), 32'h4);
    chk("midgate_cnt_en", 32'(cnt_en), 32'd1);
    reset = 1'b1;
    exp_q.delete();
    @(negedge clk);
    reset = 1'b0;
    chk("abort_osc_en", 32'(osc_en), 32'd0);
    chk("abort_cnt_en", 32'(cnt_en), 32'd0);
    chk("abort_cnt_clr", 32'(cnt_clr), 32'd1);
    chk("abort_busy", 32'(busy), 32'd0);
    repeat (2000) @(negedge clk);
    idle_check("abort");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation did not complete (cycle %0d)", cyc);
    $fatal(1, "timeout");
  end
endmodule
